// File: rtl/pio_edge_irq_pkg.sv
// Shared constants and helpers for the edge-capturing input PIO.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pio_edge_irq_pkg;

  // Widest supported input port; also the Avalon data bus width.
  localparam int MAX_WIDTH = 32;

  // Register word offsets.
  localparam logic [2:0] ADDR_DATA         = 3'd0;
  localparam logic [2:0] ADDR_RISE_EN      = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAPTURE = 3'd3;
  localparam logic [2:0] ADDR_FALL_EN      = 3'd4;
  localparam logic [2:0] ADDR_RAW          = 3'd5;

  // Ceiling log2; clog2(1) = 0, callers clamp to a 1-bit minimum.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: synchroniser chain, debounce counter, stable level and edge flags.
// Latency: SYNC_STAGES cycles to sync_o, plus DEBOUNCE_CYCLES to stable_o.
// Backpressure: none; free-running every clock.
module pio_debounce_bit
  import pio_edge_irq_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_i,
  output logic sync_o,
  output logic stable_o,
  output logic rise_raw_o,
  output logic fall_raw_o
);

  // D=1 needs no counting but keep a 1-bit counter so the logic stays uniform.
  localparam int CNT_W = (clog2(DEBOUNCE_CYCLES) < 1) ? 1 : clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   stable_q, stable_d;
  logic                   prev_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  assign sync_o = sync_q[SYNC_STAGES-1];

  // Metastability chain: shift the raw pin in from the low end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES samples.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_o != stable_q) begin
      if (cnt_q == CNT_LAST) stable_d = sync_o;
      else                   cnt_d    = cnt_q + 1'b1;
    end
  end

  // Debounced level, its one-cycle-old copy, and the persistence counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      prev_q   <= stable_q;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o   = stable_q;
  assign rise_raw_o = stable_q & ~prev_q;
  assign fall_raw_o = ~stable_q & prev_q;

endmodule

// File: rtl/pio_edge_irq.sv
// Avalon-MM input PIO with debounce, selectable edge capture (W1C) and masked irq.
// Latency: read data 1 cycle after address; edge captured S+D+1 edges after a pin change.
// Backpressure: none; slave always accepts, readdata refreshes every cycle.
module pio_edge_irq
  import pio_edge_irq_pkg::*;
#(
  parameter int WIDTH           = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_w, stable_w, rise_raw_w, fall_raw_w;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    pio_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_i      (in_port[g]),
      .sync_o    (sync_w[g]),
      .stable_o  (stable_w[g]),
      .rise_raw_o(rise_raw_w[g]),
      .fall_raw_o(fall_raw_w[g])
    );
  end

  logic [WIDTH-1:0]     rise_en_q, rise_en_d;
  logic [WIDTH-1:0]     fall_en_q, fall_en_d;
  logic [WIDTH-1:0]     mask_q, mask_d;
  logic [WIDTH-1:0]     cap_q, cap_d;
  logic [MAX_WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0]     wdata, cap_clr, edge_set;
  logic                 wr_en;
  logic                 unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;
  assign edge_set     = (rise_raw_w & rise_en_q) | (fall_raw_w & fall_en_q);

  // Register writes; a new edge in the same cycle as a clear keeps its bit set.
  always_comb begin
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    mask_d    = mask_q;
    cap_clr   = '0;
    if (wr_en) begin
      case (address)
        ADDR_RISE_EN:      rise_en_d = wdata;
        ADDR_IRQ_MASK:     mask_d    = wdata;
        ADDR_EDGE_CAPTURE: cap_clr   = wdata;
        ADDR_FALL_EN:      fall_en_d = wdata;
        default: ;
      endcase
    end
    cap_d = (cap_q & ~cap_clr) | edge_set;
  end

  // Read mux, sampled into readdata every cycle regardless of chipselect.
  always_comb begin
    rdata_d = '0;
    case (address)
      ADDR_DATA:         rdata_d[WIDTH-1:0] = stable_w;
      ADDR_RISE_EN:      rdata_d[WIDTH-1:0] = rise_en_q;
      ADDR_IRQ_MASK:     rdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE_CAPTURE: rdata_d[WIDTH-1:0] = cap_q;
      ADDR_FALL_EN:      rdata_d[WIDTH-1:0] = fall_en_q;
      ADDR_RAW:          rdata_d[WIDTH-1:0] = sync_w;
      default: ;
    endcase
  end

  // Control/status registers and registered read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_en_q <= '1;
      fall_en_q <= '1;
      mask_q    <= '0;
      cap_q     <= '0;
      rdata_q   <= '0;
    end else begin
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      mask_q    <= mask_d;
      cap_q     <= cap_d;
      rdata_q   <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  // Pure AND-OR of flop outputs, so it only moves just after a clk edge.
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_pio_edge_irq.sv
// Self-checking bench for pio_edge_irq (WIDTH=10, S=2, D=4).
// Latency: n/a.
// Backpressure: n/a.
module tb_pio_edge_irq;

  localparam int W = 10;
  localparam int S = 2;
  localparam int D = 4;
  localparam logic [W-1:0] ONES = '1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [W-1:0]  in_port = '0;
  logic [31:0]   readdata;
  logic          irq;

  always #5 clk = ~clk;

  pio_edge_irq #(
    .WIDTH          (W),
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: pin history delayed S edges, a window of the last D
  // synchronised samples, and the register file as plain variables.
  logic [W-1:0] m_pin_q[$];
  logic [W-1:0] m_win[$];
  logic [W-1:0] m_stable, m_prev, m_rise_en, m_fall_en, m_mask, m_cap;
  logic [31:0]  m_rd;

  task automatic m_reset();
    m_pin_q.delete();
    repeat (S) m_pin_q.push_back('0);
    m_win.delete();
    m_stable  = '0;
    m_prev    = '0;
    m_rise_en = ONES;
    m_fall_en = ONES;
    m_mask    = '0;
    m_cap     = '0;
    m_rd      = '0;
  endtask

  // Advance one clock (inputs already driven at the falling edge), update the
  // model and compare readdata and irq just after the rising edge.
  task automatic step();
    logic [W-1:0] sync_now, flip, ev, clr;
    logic [31:0]  rd_n;
    bit           wr, all_diff;
    sync_now = m_pin_q[0];
    m_win.push_back(sync_now);
    if (m_win.size() > D) m_win.delete(0);
    // A level is accepted once the last D samples all disagree with it.
    flip = '0;
    if (m_win.size() == D) begin
      for (int b = 0; b < W; b++) begin
        all_diff = 1'b1;
        foreach (m_win[k]) if (m_win[k][b] == m_stable[b]) all_diff = 1'b0;
        flip[b] = all_diff;
      end
    end
    ev  = (m_stable & ~m_prev & m_rise_en) | (~m_stable & m_prev & m_fall_en);
    wr  = chipselect && !write_n;
    clr = (wr && address == 3'd3) ? writedata[W-1:0] : '0;
    case (address)
      3'd0:    rd_n = 32'(m_stable);
      3'd1:    rd_n = 32'(m_rise_en);
      3'd2:    rd_n = 32'(m_mask);
      3'd3:    rd_n = 32'(m_cap);
      3'd4:    rd_n = 32'(m_fall_en);
      3'd5:    rd_n = 32'(sync_now);
      default: rd_n = 32'd0;
    endcase
    @(posedge clk);
    m_pin_q.push_back(in_port);
    m_pin_q.delete(0);
    m_prev   = m_stable;
    m_stable = m_stable ^ flip;
    m_cap    = (m_cap & ~clr) | ev;
    if (wr) begin
      case (address)
        3'd1:    m_rise_en = writedata[W-1:0];
        3'd2:    m_mask    = writedata[W-1:0];
        3'd4:    m_fall_en = writedata[W-1:0];
        default: ;
      endcase
    end
    m_rd = rd_n;
    #1;
    check_eq("model_readdata", readdata, m_rd);
    check_eq("model_irq", 32'(irq), 32'(|(m_cap & m_mask)));
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    step();
    d = readdata;
  endtask

  logic [31:0] rst_exp [6];
  logic [31:0] d;

  task automatic check_reset_regs(input string tag);
    for (int a = 0; a < 6; a++) begin
      bus_rd(3'(a), d);
      check_eq($sformatf("%s_reg%0d", tag, a), d, rst_exp[a]);
    end
    check_eq({tag, "_irq"}, 32'(irq), 32'd0);
  endtask

  initial begin
    rst_exp = '{32'h0, 32'h3FF, 32'h0, 32'h0, 32'h3FF, 32'h0};

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("in_reset_readdata", readdata, 32'd0);
    check_eq("in_reset_irq", 32'(irq), 32'd0);
    m_reset();
    reset_n = 1'b1;
    check_reset_regs("reset");

    // Debounce: a 3-cycle glitch is filtered, a held level captures at edge 7
    bus_wr(3'd2, 32'h008);
    in_port[3] = 1'b1;
    run(3);
    in_port[3] = 1'b0;
    run(8);
    check_eq("glitch_irq", 32'(irq), 32'd0);
    bus_rd(3'd3, d);
    check_eq("glitch_capture", d, 32'h0);
    in_port[3] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 6) check_eq("edge6_irq_low", 32'(irq), 32'd0);
      if (k == 7) check_eq("edge7_irq_high", 32'(irq), 32'd1);
    end
    bus_rd(3'd3, d);
    check_eq("held_capture", d, 32'h008);
    in_port[3] = 1'b0;
    run(8);
    bus_wr(3'd3, 32'(ONES));
    bus_wr(3'd2, 32'h0);

    // Edge select: rise only
    bus_wr(3'd4, 32'h0);
    bus_wr(3'd2, 32'h001);
    in_port[0] = 1'b1;
    run(8);
    check_eq("rise_only_irq", 32'(irq), 32'd1);
    bus_rd(3'd3, d);
    check_eq("rise_only_capture", d, 32'h001);
    bus_wr(3'd3, 32'h001);
    check_eq("cleared_irq", 32'(irq), 32'd0);
    in_port[0] = 1'b0;
    run(8);
    bus_rd(3'd3, d);
    check_eq("fall_ignored_capture", d, 32'h0);
    check_eq("fall_ignored_irq", 32'(irq), 32'd0);

    // W1C colliding with a fresh rise on bit 2
    in_port[0] = 1'b1;
    in_port[2] = 1'b1;
    run(8);
    bus_rd(3'd3, d);
    check_eq("pending_005", d, 32'h005);
    in_port[2] = 1'b0;
    run(8);
    in_port[2] = 1'b1;
    run(6);
    bus_wr(3'd3, 32'h005);
    bus_rd(3'd3, d);
    check_eq("w1c_set_wins", d, 32'h004);
    bus_wr(3'd4, 32'(ONES));
    bus_wr(3'd2, 32'h0);
    in_port = '0;
    run(8);
    bus_wr(3'd3, 32'(ONES));

    // Mask gating
    in_port[9] = 1'b1;
    run(8);
    check_eq("masked_irq", 32'(irq), 32'd0);
    bus_rd(3'd3, d);
    check_eq("masked_capture", d, 32'h200);
    bus_wr(3'd2, 32'h200);
    check_eq("unmask_irq", 32'(irq), 32'd1);
    in_port[9] = 1'b0;
    run(8);
    bus_wr(3'd3, 32'(ONES));
    bus_wr(3'd2, 32'h0);

    // Randomised traffic against the model
    for (int c = 0; c < 1000; c++) begin
      int op;
      for (int b = 0; b < W; b++) begin
        if ($urandom_range(0, (c < 500) ? 5 : 11) == 0) in_port[b] = ~in_port[b];
      end
      op        = int'($urandom_range(0, 3));
      address   = 3'($urandom_range(0, 7));
      writedata = $urandom;
      case (op)
        0:       begin chipselect = 1'b1; write_n = 1'b0; end
        1:       begin chipselect = 1'b0; write_n = 1'b0; end
        default: begin chipselect = 1'($urandom_range(0, 1)); write_n = 1'b1; end
      endcase
      step();
    end
    chipselect = 1'b0;
    write_n    = 1'b1;

    // Mid-run reset with captures, masks and counters in flight
    bus_wr(3'd2, 32'(ONES));
    in_port = 10'h155;
    run(8);
    in_port = 10'h0AA;
    run(2);
    reset_n = 1'b0;
    #1;
    check_eq("midreset_readdata", readdata, 32'd0);
    check_eq("midreset_irq", 32'(irq), 32'd0);
    in_port = '0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check_reset_regs("after_midreset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
